// File: rtl/reg_bank_wr_arbiter.sv
// Round-robin write arbiter for a 4-entry register bank.
// Three requesters issue bursts of 1-4 beats. The burst owner is never preempted.
module reg_bank_wr_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [5:0]  req_len,
    input  logic [5:0]  req_dr,
    input  logic [95:0] req_data,
    output logic [2:0]  ack,
    output logic        write,
    output logic [1:0]  dr,
    output logic [31:0] wrData,
    output logic [1:0]  gnt_id,
    output logic        busy
);

    localparam int unsigned NREQ = 3;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 2;
    localparam int unsigned LW   = 2;
    localparam int unsigned IDW  = 2;

    typedef enum logic {IDLE, BURST} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            write_q, write_d;
    logic [AW-1:0]   dr_q, dr_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [IDW-1:0]  gnt_id_q, gnt_id_d;
    logic [NREQ-1:0] ack_c;

    logic [LW-1:0]   len_a  [NREQ];
    logic [AW-1:0]   dr_a   [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    logic [IDW-1:0]  cand1, cand2, pick_id;
    logic            pick_vld;

    // Wrapping increment over the requester ids 0..NREQ-1
    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NREQ - 1)) ? '0 : id + IDW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            len_a[i]  = req_len[LW*i +: LW];
            dr_a[i]   = req_dr[AW*i +: AW];
            data_a[i] = req_data[DW*i +: DW];
        end
    end

    // Round-robin pick: first requesting id starting from rr_ptr
    always_comb begin
        cand1    = next_id(rr_ptr_q);
        cand2    = next_id(cand1);
        pick_vld = 1'b1;
        pick_id  = rr_ptr_q;
        if (req[rr_ptr_q]) begin
            pick_id = rr_ptr_q;
        end else if (req[cand1]) begin
            pick_id = cand1;
        end else if (req[cand2]) begin
            pick_id = cand2;
        end else begin
            pick_vld = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        write_d   = 1'b0;
        dr_d      = dr_q;
        wr_data_d = wr_data_q;
        gnt_id_d  = gnt_id_q;
        ack_c     = '0;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    ack_c     = NREQ'(1) << pick_id;
                    write_d   = 1'b1;
                    dr_d      = dr_a[pick_id];
                    wr_data_d = data_a[pick_id];
                    gnt_id_d  = pick_id;
                    owner_d   = pick_id;
                    if (len_a[pick_id] != '0) begin
                        state_d = BURST;
                        rem_d   = len_a[pick_id];
                        addr_d  = dr_a[pick_id] + AW'(1);
                    end else begin
                        rr_ptr_d = next_id(pick_id);
                    end
                end
            end
            BURST: begin
                // Owner deasserting req stalls the burst in place
                if (req[owner_q]) begin
                    ack_c     = NREQ'(1) << owner_q;
                    write_d   = 1'b1;
                    dr_d      = addr_q;
                    wr_data_d = data_a[owner_q];
                    gnt_id_d  = owner_q;
                    addr_d    = addr_q + AW'(1);
                    rem_d     = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_id(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            ack_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            dr_q      <= '0;
            wr_data_q <= '0;
            gnt_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            dr_q      <= dr_d;
            wr_data_q <= wr_data_d;
            gnt_id_q  <= gnt_id_d;
        end
    end

    assign ack    = ack_c;
    assign write  = write_q;
    assign dr     = dr_q;
    assign wrData = wr_data_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == BURST);

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// Directed bench for reg_bank_wr_arbiter: a per-cycle vector table plus a reset-mid-burst sequence.
module tb_reg_bank_wr_arbiter;

    typedef struct {
        logic        rst;
        logic [2:0]  req;
        logic [5:0]  len;
        logic [5:0]  drs;
        logic [95:0] data;
        logic [2:0]  e_ack;
        logic        e_write;
        logic [1:0]  e_dr;
        logic [31:0] e_data;
        logic [1:0]  e_gid;
        logic        e_busy;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [5:0]  req_len;
    logic [5:0]  req_dr;
    logic [95:0] req_data;
    logic [2:0]  ack;
    logic        write;
    logic [1:0]  dr;
    logic [31:0] wr_data;
    logic [1:0]  gnt_id;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [22];

    reg_bank_wr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_len  (req_len),
        .req_dr   (req_dr),
        .req_data (req_data),
        .ack      (ack),
        .write    (write),
        .dr       (dr),
        .wrData   (wr_data),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [5:0] ln,
                                input logic [5:0] ds, input logic [95:0] dt, input logic [2:0] ea,
                                input logic ew, input logic [1:0] ed, input logic [31:0] edt,
                                input logic [1:0] eg, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.len = ln; v.drs = ds; v.data = dt;
        v.e_ack = ea; v.e_write = ew; v.e_dr = ed; v.e_data = edt; v.e_gid = eg; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [2:0] rq, input logic [5:0] ln,
                         input logic [5:0] ds, input logic [95:0] dt);
        @(negedge clk);
        rst = r; req = rq; req_len = ln; req_dr = ds; req_data = dt;
        #1;
    endtask

    task automatic chk_outs(input string p, input logic [2:0] ea, input logic ew,
                            input logic [1:0] ed, input logic [31:0] edt,
                            input logic [1:0] eg, input logic eb);
        chk({p, "_ack"},   32'(ack),     32'(ea));
        chk({p, "_write"}, 32'(write),   32'(ew));
        chk({p, "_dr"},    32'(dr),      32'(ed));
        chk({p, "_data"},  wr_data,      edt);
        chk({p, "_gid"},   32'(gnt_id),  32'(eg));
        chk({p, "_busy"},  32'(busy),    32'(eb));
    endtask

    initial begin
        logic [31:0] d;
        logic [95:0] d0, rr, bw, st, cw;
        d  = 32'hDEADBEEF;
        d0 = {64'h0, d};
        rr = {32'd2, 32'd1, 32'd0};
        bw = {32'h0, 32'hA1, 32'hA0};
        st = {32'h0, 32'hB1, 32'h0};
        cw = {32'h0, 32'hC1, 32'hC0};

        // Single write, then reset so round-robin starts at requester 0
        vecs[0]  = mk(1'b1, 3'b001, 6'h00, 6'b000010, d0, 3'b000, 1'b0, 2'd0, 32'h0,  2'd0, 1'b0);
        vecs[1]  = mk(1'b0, 3'b001, 6'h00, 6'b000010, d0, 3'b001, 1'b0, 2'd0, 32'h0,  2'd0, 1'b0);
        vecs[2]  = mk(1'b0, 3'b000, 6'h00, 6'b000010, d0, 3'b000, 1'b1, 2'd2, d,      2'd0, 1'b0);
        vecs[3]  = mk(1'b1, 3'b000, 6'h00, 6'b000010, d0, 3'b000, 1'b0, 2'd2, d,      2'd0, 1'b0);
        // Round-robin over three single-beat requesters
        vecs[4]  = mk(1'b0, 3'b111, 6'h00, 6'b100100, rr, 3'b001, 1'b0, 2'd0, 32'd0,  2'd0, 1'b0);
        vecs[5]  = mk(1'b0, 3'b111, 6'h00, 6'b100100, rr, 3'b010, 1'b1, 2'd0, 32'd0,  2'd0, 1'b0);
        vecs[6]  = mk(1'b0, 3'b111, 6'h00, 6'b100100, rr, 3'b100, 1'b1, 2'd1, 32'd1,  2'd1, 1'b0);
        vecs[7]  = mk(1'b0, 3'b111, 6'h00, 6'b100100, rr, 3'b001, 1'b1, 2'd2, 32'd2,  2'd2, 1'b0);
        vecs[8]  = mk(1'b0, 3'b000, 6'h00, 6'b100100, rr, 3'b000, 1'b1, 2'd0, 32'd0,  2'd0, 1'b0);
        // 4-beat burst from requester 1 at base 3 (wraps), requester 0 waiting
        vecs[9]  = mk(1'b0, 3'b011, 6'b001100, 6'b001100, bw, 3'b010, 1'b0, 2'd0, 32'd0, 2'd0, 1'b0);
        vecs[10] = mk(1'b0, 3'b011, 6'b001100, 6'b001100, bw, 3'b010, 1'b1, 2'd3, 32'hA1, 2'd1, 1'b1);
        vecs[11] = mk(1'b0, 3'b011, 6'b001100, 6'b001100, bw, 3'b010, 1'b1, 2'd0, 32'hA1, 2'd1, 1'b1);
        vecs[12] = mk(1'b0, 3'b011, 6'b001100, 6'b001100, bw, 3'b010, 1'b1, 2'd1, 32'hA1, 2'd1, 1'b1);
        vecs[13] = mk(1'b0, 3'b011, 6'b001100, 6'b001100, bw, 3'b001, 1'b1, 2'd2, 32'hA1, 2'd1, 1'b0);
        vecs[14] = mk(1'b0, 3'b000, 6'b001100, 6'b001100, bw, 3'b000, 1'b1, 2'd0, 32'hA0, 2'd0, 1'b0);
        // Burst with a 2-cycle stall after beat 1
        vecs[15] = mk(1'b0, 3'b010, 6'b001100, 6'b000100, st, 3'b010, 1'b0, 2'd0, 32'hA0, 2'd0, 1'b0);
        vecs[16] = mk(1'b0, 3'b010, 6'b001100, 6'b000100, st, 3'b010, 1'b1, 2'd1, 32'hB1, 2'd1, 1'b1);
        vecs[17] = mk(1'b0, 3'b000, 6'b001100, 6'b000100, st, 3'b000, 1'b1, 2'd2, 32'hB1, 2'd1, 1'b1);
        vecs[18] = mk(1'b0, 3'b000, 6'b001100, 6'b000100, st, 3'b000, 1'b0, 2'd2, 32'hB1, 2'd1, 1'b1);
        vecs[19] = mk(1'b0, 3'b010, 6'b001100, 6'b000100, st, 3'b010, 1'b0, 2'd2, 32'hB1, 2'd1, 1'b1);
        vecs[20] = mk(1'b0, 3'b010, 6'b001100, 6'b000100, st, 3'b010, 1'b1, 2'd3, 32'hB1, 2'd1, 1'b1);
        vecs[21] = mk(1'b0, 3'b000, 6'b001100, 6'b000100, st, 3'b000, 1'b1, 2'd0, 32'hB1, 2'd1, 1'b0);

        rst = 1'b1; req = '0; req_len = '0; req_dr = '0; req_data = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].len, vecs[i].drs, vecs[i].data);
            chk_outs($sformatf("r%0d", i), vecs[i].e_ack, vecs[i].e_write, vecs[i].e_dr,
                     vecs[i].e_data, vecs[i].e_gid, vecs[i].e_busy);
        end

        // Reset after beat 1 of a 4-beat burst; rr_ptr is 2 entering this sequence
        drive(1'b0, 3'b010, 6'b001100, 6'b000001, cw);
        chk_outs("rb_a", 3'b010, 1'b0, 2'd0, 32'hB1, 2'd1, 1'b0);
        drive(1'b0, 3'b010, 6'b001100, 6'b000001, cw);
        chk_outs("rb_b", 3'b010, 1'b1, 2'd0, 32'hC1, 2'd1, 1'b1);
        drive(1'b1, 3'b011, 6'b001100, 6'b000001, cw);
        chk_outs("rb_c", 3'b000, 1'b1, 2'd1, 32'hC1, 2'd1, 1'b1);
        drive(1'b0, 3'b011, 6'b001100, 6'b000001, cw);
        chk_outs("rb_d", 3'b001, 1'b0, 2'd0, 32'h0, 2'd0, 1'b0);
        drive(1'b0, 3'b010, 6'b001100, 6'b000001, cw);
        chk_outs("rb_e", 3'b010, 1'b1, 2'd1, 32'hC0, 2'd0, 1'b0);
        drive(1'b0, 3'b000, 6'b001100, 6'b000001, cw);
        chk_outs("rb_f", 3'b000, 1'b1, 2'd0, 32'hC1, 2'd1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_bank_wr_arbiter.md
REG_BANK_WR_ARBITER -- requirements
Module: reg_bank_wr_arbiter

Parameters
REQ-001 The block SHALL have no parameters: NREQ = 3 requesters, DW = 32 data bits and AW = 2 address bits are fixed.

Interface
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 req  in  3  per-requester write request; bit i belongs to requester i.
REQ-005 req_len  in  6  burst length minus one; bits [2i+1:2i] belong to requester i; values 0..3 mean 1..4 beats.
REQ-006 req_dr  in  6  burst base destination register; bits [2i+1:2i] belong to requester i.
REQ-007 req_data  in  96  write data; bits [32i+31:32i] belong to requester i.
REQ-008 ack  out  3  combinational one-hot beat-accept strobe; bit i is for requester i.
REQ-009 write  out  1  registered write enable to the register bank.
REQ-010 dr  out  2  registered destination register.
REQ-011 wrData  out  32  registered write data.
REQ-012 gnt_id  out  2  registered id of the requester that owns the current write; value 3 SHALL never occur.
REQ-013 busy  out  1  high while the FSM is in BURST.

Function
REQ-014 The FSM SHALL have two states: IDLE and BURST. It SHALL also hold:
- rr_ptr (0..2),
- owner id,
- remaining count (2 bits),
- next address (2 bits).
REQ-015 IDLE arbitration SHALL be round-robin. When any req bit is high, the block SHALL grant the first high bit in the order rr_ptr, rr_ptr+1, rr_ptr+2, taken mod 3.
REQ-016 IDLE grant cycle: ack[id] SHALL be 1 in the same cycle (beat 0 accepted). In that cycle req_len[id] and req_dr[id] SHALL be sampled. Both are ignored on later beats.
REQ-017 Every accepted beat in cycle N SHALL produce write=1, dr=beat address, wrData=req_data[id] and gnt_id=id in cycle N+1.
REQ-018 In any cycle with no accepted beat, write SHALL be 0 in the next cycle. dr, wrData and gnt_id SHALL hold their previous values.
REQ-019 Beat k SHALL use address (base + k) mod 4; the address wraps from 3 to 0.
REQ-020 IDLE -> BURST SHALL occur when the sampled len > 0, with remaining = len. When len = 0 the FSM SHALL stay in IDLE.
REQ-021 BURST with req[id] = 1:
- ack[id] SHALL be 1 and the beat SHALL be accepted;
- remaining SHALL decrement;
- when the accepted beat is the last one (remaining was 1), the next state SHALL be IDLE.
REQ-022 BURST with req[id] = 0: the block SHALL stall; there is no ack and no state change.
REQ-023 The burst owner SHALL never be preempted. During BURST, ack bits of other requesters SHALL be 0.
REQ-024 rr_ptr SHALL load (id+1) mod 3 in the cycle the final beat of a grant is accepted; this includes len = 0 grants.
REQ-025 No bubble: the cycle after a final beat is IDLE and SHALL be able to ack. Continuous requests SHALL therefore yield write = 1 every cycle.
REQ-026 Requesters SHALL hold req and their data stable until acked. ack SHALL be at most one-hot.
REQ-027 busy SHALL be 1 exactly when the state is BURST.

Reset
REQ-028 While rst = 1 at a rising edge, the block SHALL set:
- state = IDLE, rr_ptr = 0, remaining = 0;
- write = 0, dr = 0, wrData = 0, gnt_id = 0.
REQ-029 While rst = 1, ack SHALL be forced to 0.
REQ-030 Reset mid-burst SHALL abort the burst: no further writes, and the requester restarts from beat 0.

Verification
REQ-031 Single write: after reset, drive req=001, len0=0, dr0=2, data0=0xDEADBEEF.
- Same cycle: ack=001.
- Next cycle: write=1, dr=2, wrData=0xDEADBEEF, gnt_id=0.
- busy stays 0.
REQ-032 Round-robin: hold req=111 with all len=0 and data_i=i.
- ack sequence: 001, 010, 100, 001.
- write=1 on every cycle.
- gnt_id sequence: 0, 1, 2, 0.
REQ-033 Burst with wrap: req1 with len=3, dr=3, while req0 is also held high.
- Writes to dr 3, 0, 1, 2 with gnt_id=1 on 4 consecutive cycles.
- busy=1 on beats 1..3.
- ack[0] first rises the cycle after the final beat is accepted.
REQ-034 Stall: drop req1 for 2 cycles mid-burst.
- No ack in those cycles; write=0 in the 2 following cycles.
- Addresses resume at the next expected value with no skip or repeat.
REQ-035 Reset mid-burst: pulse rst for 1 cycle after beat 1 of a len=3 burst.
- write=0 and busy=0 after reset.
- rr_ptr=0, so with req=011 the next grant goes to requester 0.
